// File: rtl/instr_loader_pkg.sv
// Shared definitions for the program loader and its instruction store.
//   DEPTH   : number of instruction words in the store
//   WORD_W  : instruction word width
//   IDX_W   : store index width
//   loader_state_t : loader FSM state encoding
package instr_loader_pkg;

  localparam int DEPTH  = 8;
  localparam int WORD_W = 16;
  localparam int IDX_W  = $clog2(DEPTH);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LEN  = 3'd1,
    HI   = 3'd2,
    LO   = 3'd3,
    DONE = 3'd4,
    ERR  = 3'd5
  } loader_state_t;

endpackage

// File: rtl/instr_store.sv
// Instruction store: DEPTH x WORD_W array, one synchronous write port and
// one combinational read port. All entries clear asynchronously on rst_n.
//   clk, rst_n : clock, async active-low clear
//   we, waddr, wdata : write port
//   raddr, rdata     : combinational read port
module instr_store
  import instr_loader_pkg::*;
#(
  parameter int D = DEPTH,
  parameter int W = WORD_W,
  parameter int A = IDX_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         we,
  input  logic [A-1:0] waddr,
  input  logic [W-1:0] wdata,
  input  logic [A-1:0] raddr,
  output logic [W-1:0] rdata
);

  logic [W-1:0] mem [D];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < D; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/instr_loader.sv
// Program loader: receives a length-prefixed big-endian byte stream over a
// valid/ready handshake and writes 16-bit words into the instruction store.
// The fetch port reads the store by pc and is forced to zero while loading.
//   clk, rst_n           : clock, async active-low reset
//   start                : begin a load frame (ignored while busy)
//   in_valid/in_data/in_ready : byte stream handshake
//   pc / instruction     : fetch port (index pc[3:1])
//   cpu_hold, busy       : frame in progress
//   done, err            : last frame completed / had illegal length
//   word_count           : words written in the current or last frame
//
// state | meaning
// IDLE  | no frame since reset
// LEN   | waiting for the length byte N
// HI    | waiting for the high byte of the next word
// LO    | waiting for the low byte; writes the word on accept
// DONE  | N words written
// ERR   | length byte was 0 or larger than DEPTH
module instr_loader
  import instr_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  input  logic [15:0] pc,
  output logic [15:0] instruction,
  output logic        cpu_hold,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [3:0]  word_count
);

  localparam logic [7:0] DEPTH_B = 8'(DEPTH);

  loader_state_t state;
  logic [3:0]    n_len;
  logic [7:0]    hi_byte;
  logic [3:0]    wc_next;
  logic          store_we;
  logic [WORD_W-1:0] store_rdata;
  logic          unused_pc_bits;

  assign wc_next  = word_count + 4'd1;
  assign store_we = (state == LO) && in_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      n_len      <= '0;
      hi_byte    <= '0;
      word_count <= '0;
    end else begin
      case (state)
        IDLE, DONE, ERR: begin
          if (start) begin
            state      <= LEN;
            word_count <= '0;
          end
        end
        LEN: begin
          if (in_valid) begin
            if (in_data == 8'd0 || in_data > DEPTH_B) begin
              state <= ERR;
            end else begin
              n_len <= in_data[3:0];
              state <= HI;
            end
          end
        end
        HI: begin
          if (in_valid) begin
            hi_byte <= in_data;
            state   <= LO;
          end
        end
        LO: begin
          if (in_valid) begin
            word_count <= wc_next;
            state      <= (wc_next == n_len) ? DONE : HI;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy     = (state == LEN) || (state == HI) || (state == LO);
  assign in_ready = busy;
  assign cpu_hold = busy;
  assign done     = (state == DONE);
  assign err      = (state == ERR);

  instr_store u_store (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (store_we),
    .waddr (word_count[IDX_W-1:0]),
    .wdata ({hi_byte, in_data}),
    .raddr (pc[IDX_W:1]),
    .rdata (store_rdata)
  );

  // Upper pc bits alias and pc[0] is a byte offset within the word.
  assign unused_pc_bits = ^{pc[15:IDX_W+1], pc[0]};

  // No write/read bypass needed: reads are blanked for the whole frame.
  assign instruction = busy ? 16'h0000 : store_rdata;

endmodule

// File: tb/tb_instr_loader.sv
module tb_instr_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic [15:0] pc;
  logic [15:0] instruction;
  logic        cpu_hold;
  logic        busy;
  logic        done;
  logic        err;
  logic [3:0]  word_count;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  instr_loader dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .pc          (pc),
    .instruction (instruction),
    .cpu_hold    (cpu_hold),
    .busy        (busy),
    .done        (done),
    .err         (err),
    .word_count  (word_count)
  );

  typedef struct {
    logic        st;
    logic        vld;
    logic [7:0]  dat;
    logic [15:0] pcv;
    logic        e_busy;
    logic        e_done;
    logic        e_err;
    logic        e_rdy;
    logic [3:0]  e_wc;
    logic [15:0] e_instr;
  } vec_t;

  vec_t vecs [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_status(input string tag, input logic b, input logic d,
                            input logic e, input logic [3:0] wc);
    chk({tag, " busy"}, {31'd0, busy}, {31'd0, b});
    chk({tag, " cpu_hold"}, {31'd0, cpu_hold}, {31'd0, b});
    chk({tag, " in_ready"}, {31'd0, in_ready}, {31'd0, b});
    chk({tag, " done"}, {31'd0, done}, {31'd0, d});
    chk({tag, " err"}, {31'd0, err}, {31'd0, e});
    chk({tag, " word_count"}, {28'd0, word_count}, {28'd0, wc});
  endtask

  task automatic chk_mem(input string tag, input logic [15:0] addr, input logic [15:0] exp);
    pc = addr;
    #1;
    chk({tag, " instr"}, {16'd0, instruction}, {16'd0, exp});
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  // Transfer one byte after `gap` idle cycles; cpu_hold must stay high during gaps.
  task automatic xfer(input logic [7:0] b, input int gap, input logic hold_chk);
    in_valid = 1'b0;
    for (int g = 0; g < gap; g++) begin
      cyc();
      if (hold_chk) chk("gap cpu_hold", {31'd0, cpu_hold}, 32'd1);
    end
    in_valid = 1'b1;
    in_data  = b;
    cyc();
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #3;
    rst_n = 1'b1;
    cyc();
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = 8'h00; pc = 16'h0;
    repeat (2) cyc();
    rst_n = 1'b1;
    cyc();

    // Two-word frame, in_valid constant. Values are after each rising edge.
    //          st   vld  dat    pc      busy done err  rdy  wc    instr
    vecs[0] = '{1'b1,1'b0,8'h00,16'h0000,1'b1,1'b0,1'b0,1'b1,4'd0,16'h0000};
    vecs[1] = '{1'b0,1'b1,8'h02,16'h0000,1'b1,1'b0,1'b0,1'b1,4'd0,16'h0000};
    vecs[2] = '{1'b0,1'b1,8'h40,16'h0000,1'b1,1'b0,1'b0,1'b1,4'd0,16'h0000};
    vecs[3] = '{1'b0,1'b1,8'h02,16'h0000,1'b1,1'b0,1'b0,1'b1,4'd1,16'h0000};
    vecs[4] = '{1'b0,1'b1,8'h50,16'h0002,1'b1,1'b0,1'b0,1'b1,4'd1,16'h0000};
    vecs[5] = '{1'b0,1'b1,8'h81,16'h0000,1'b0,1'b1,1'b0,1'b0,4'd2,16'h4002};
    vecs[6] = '{1'b0,1'b1,8'hEE,16'h0002,1'b0,1'b1,1'b0,1'b0,4'd2,16'h5081};
    vecs[7] = '{1'b0,1'b0,8'h00,16'h0010,1'b0,1'b1,1'b0,1'b0,4'd2,16'h4002};
    vecs[8] = '{1'b0,1'b0,8'h00,16'h0004,1'b0,1'b1,1'b0,1'b0,4'd2,16'h0000};

    for (int i = 0; i < 9; i++) begin
      start = vecs[i].st; in_valid = vecs[i].vld; in_data = vecs[i].dat; pc = vecs[i].pcv;
      cyc();
      chk_status($sformatf("vec%0d", i), vecs[i].e_busy, vecs[i].e_done,
                 vecs[i].e_err, vecs[i].e_wc);
      chk($sformatf("vec%0d instr", i), {16'd0, instruction}, {16'd0, vecs[i].e_instr});
    end
    start = 1'b0; in_valid = 1'b0;

    // Reset mid-simulation clears outputs and every store entry.
    rst_n = 1'b0;
    #2;
    chk_status("reset", 1'b0, 1'b0, 1'b0, 4'd0);
    for (int a = 0; a < 16; a += 2) chk_mem($sformatf("reset pc%0d", a), 16'(a), 16'h0000);
    rst_n = 1'b1;
    cyc();

    // Gapped stream: valid pattern 1,0,0,1,...
    pulse_start();
    xfer(8'h02, 0, 1'b1);
    xfer(8'h40, 2, 1'b1);
    xfer(8'h02, 2, 1'b1);
    xfer(8'h50, 2, 1'b1);
    chk("gap busy before last", {31'd0, cpu_hold}, 32'd1);
    xfer(8'h81, 2, 1'b1);
    chk_status("gapped", 1'b0, 1'b1, 1'b0, 4'd2);
    chk_mem("gapped pc0", 16'h0000, 16'h4002);
    chk_mem("gapped pc2", 16'h0002, 16'h5081);
    chk_mem("gapped pc4", 16'h0004, 16'h0000);

    // Illegal lengths leave the store untouched.
    pulse_start();
    xfer(8'h09, 0, 1'b0);
    chk_status("len9", 1'b0, 1'b0, 1'b1, 4'd0);
    in_valid = 1'b1; in_data = 8'h77;
    cyc();
    in_valid = 1'b0;
    chk("len9 in_ready stays 0", {31'd0, in_ready}, 32'd0);
    chk_mem("len9 pc0", 16'h0000, 16'h4002);
    chk_mem("len9 pc2", 16'h0002, 16'h5081);
    pulse_start();
    chk("restart clears err", {31'd0, err}, 32'd0);
    xfer(8'h00, 1, 1'b0);
    chk_status("len0", 1'b0, 1'b0, 1'b1, 4'd0);
    chk_mem("len0 pc0", 16'h0000, 16'h4002);
    chk_mem("len0 pc2", 16'h0002, 16'h5081);

    // Length 8 is the largest legal frame.
    pulse_start();
    xfer(8'h08, 0, 1'b0);
    for (int w = 0; w < 8; w++) begin
      xfer(8'hA0 + 8'(w), 0, 1'b0);
      xfer(8'h10 + 8'(w), 0, 1'b0);
    end
    chk_status("len8", 1'b0, 1'b1, 1'b0, 4'd8);
    chk_mem("len8 pc14", 16'h000E, 16'hA717);
    chk_mem("len8 pc0", 16'h0000, 16'hA010);

    // Reset mid-frame after 0x03, 0x12 are accepted.
    pulse_start();
    xfer(8'h03, 0, 1'b0);
    xfer(8'h12, 0, 1'b0);
    do_reset();
    chk_status("midreset", 1'b0, 1'b0, 1'b0, 4'd0);
    for (int a = 0; a < 16; a += 2) chk_mem($sformatf("midreset pc%0d", a), 16'(a), 16'h0000);
    pulse_start();
    xfer(8'h03, 0, 1'b0);
    xfer(8'hA1, 0, 1'b0); xfer(8'hB2, 0, 1'b0);
    xfer(8'hC3, 0, 1'b0); xfer(8'hD4, 0, 1'b0);
    xfer(8'hE5, 0, 1'b0); xfer(8'hF6, 0, 1'b0);
    chk_status("after midreset", 1'b0, 1'b1, 1'b0, 4'd3);
    chk_mem("after midreset pc0", 16'h0000, 16'hA1B2);
    chk_mem("after midreset pc2", 16'h0002, 16'hC3D4);
    chk_mem("after midreset pc4", 16'h0004, 16'hE5F6);
    chk_mem("after midreset pc6", 16'h0006, 16'h0000);

    // start during HI is ignored; instruction reads 0 while busy.
    pulse_start();
    xfer(8'h02, 0, 1'b0);
    xfer(8'h11, 0, 1'b0);
    xfer(8'h22, 0, 1'b0);
    pc = 16'h0000;
    pulse_start();
    chk("busy start ignored wc", {28'd0, word_count}, 32'd1);
    chk("busy instr forced 0", {16'd0, instruction}, 32'd0);
    xfer(8'h33, 0, 1'b0);
    xfer(8'h44, 0, 1'b0);
    chk_status("start-in-HI", 1'b0, 1'b1, 1'b0, 4'd2);
    chk_mem("start-in-HI pc0", 16'h0000, 16'h1122);
    chk_mem("start-in-HI pc2", 16'h0002, 16'h3344);

    // Length-1 frame overwrites only entry 0.
    pulse_start();
    xfer(8'h01, 0, 1'b0);
    xfer(8'h55, 0, 1'b0);
    xfer(8'h66, 0, 1'b0);
    chk_status("len1", 1'b0, 1'b1, 1'b0, 4'd1);
    chk_mem("len1 pc0", 16'h0000, 16'h5566);
    chk_mem("len1 pc3 alias", 16'h0003, 16'h3344);
    chk_mem("len1 pc4", 16'h0004, 16'hE5F6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
